// File: rtl/jtag_scan_sequencer.sv
// JTAG master: turns queued IR/DR scan commands into TCK/TMS/TDI waveforms and returns captured TDO bits.
// Latency: DR scan takes (eff_len+5) TCK periods and IR scan takes (eff_len+6); a zero-length command responds on the next cycle.
// Backpressure: cmd_ready is high only while parked in IDLE; a response is held, with TCK stopped, until rsp_ready.
module jtag_scan_sequencer #(
    parameter int TCK_DIV = 4,
    parameter int MAX_LEN = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic [6:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_TCK,
    output logic               jtag_TMS,
    output logic               jtag_TDI,
    output logic               jtag_TRSTn,
    input  logic               jtag_TDO_data,
    input  logic               jtag_TDO_driven
);

    typedef enum logic [2:0] {
        S_INIT_TRST,
        S_INIT_TLR,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_RESP
    } state_t;

    localparam int             DW       = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int             IW       = $clog2(MAX_LEN);
    localparam logic [DW-1:0]  DIV_LAST = DW'(TCK_DIV - 1);
    localparam logic [6:0]     MAX_LEN7 = 7'(MAX_LEN);

    state_t             state_q;
    state_t             state_nxt;
    logic [6:0]         idx_q;
    logic [6:0]         idx_nxt;
    logic [6:0]         last_idx;
    logic [DW-1:0]      div_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               trstn_q;
    logic               ir_q;
    logic [6:0]         len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;

    logic               active;
    logic               next_active;
    logic               tick;
    logic               rise;
    logic               fall;
    logic               accept;
    logic [6:0]         eff_len;
    logic               tdo_bit;
    logic               tms_d;
    logic               tdi_d;

    // TCK runs only in the sequencing states; IDLE and RESP park it low.
    assign active      = (state_q == S_INIT_TRST) || (state_q == S_INIT_TLR) ||
                         (state_q == S_PRE) || (state_q == S_SHIFT) || (state_q == S_POST);
    assign next_active = (state_nxt == S_INIT_TRST) || (state_nxt == S_INIT_TLR) ||
                         (state_nxt == S_PRE) || (state_nxt == S_SHIFT) || (state_nxt == S_POST);
    assign tick        = active && (div_q == DIV_LAST);
    assign rise        = tick && !tck_q;
    assign fall        = tick && tck_q;
    assign accept      = cmd_valid && (state_q == S_IDLE);
    assign eff_len     = (cmd_len > MAX_LEN7) ? MAX_LEN7 : cmd_len;
    assign tdo_bit     = jtag_TDO_driven && jtag_TDO_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT_TRST;
            idx_q   <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
        end
    end

    // idx counts TCK periods within the current phase and advances on the falling edge.
    always_comb begin
        last_idx = 7'd0;
        case (state_q)
            S_INIT_TRST: last_idx = 7'd1;
            S_INIT_TLR:  last_idx = 7'd5;
            S_PRE:       last_idx = ir_q ? 7'd3 : 7'd2;
            S_SHIFT:     last_idx = len_q - 7'd1;
            S_POST:      last_idx = 7'd1;
            default:     last_idx = 7'd0;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (eff_len == 7'd0) ? S_RESP : S_PRE;
                    idx_nxt   = 7'd0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                if (fall) begin
                    if (idx_q == last_idx) begin
                        idx_nxt = 7'd0;
                        case (state_q)
                            S_INIT_TRST: state_nxt = S_INIT_TLR;
                            S_INIT_TLR:  state_nxt = S_IDLE;
                            S_PRE:       state_nxt = S_SHIFT;
                            S_SHIFT:     state_nxt = S_POST;
                            default:     state_nxt = S_RESP;
                        endcase
                    end else begin
                        idx_nxt = idx_q + 7'd1;
                    end
                end
            end
        endcase
    end

    // Pin values are decoded from the next state so they register together with the falling edge.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        tdi_d     = 1'b0;
        tms_d     = 1'b0;
        case (state_nxt)
            S_INIT_TRST: tms_d = 1'b1;
            S_INIT_TLR:  tms_d = (idx_nxt < 7'd5);
            S_PRE:       tms_d = ir_q ? (idx_nxt < 7'd2) : (idx_nxt == 7'd0);
            S_SHIFT: begin
                tms_d = (idx_nxt == (len_q - 7'd1));
                tdi_d = data_q[idx_nxt[IW-1:0]];
            end
            S_POST:      tms_d = (idx_nxt == 7'd0);
            default:     tms_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            trstn_q <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
        end else begin
            if (!active || !next_active) begin
                div_q <= '0;
                tck_q <= 1'b0;
            end else if (tick) begin
                div_q <= '0;
                tck_q <= !tck_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trstn_q <= (state_nxt != S_INIT_TRST);
            if (accept) begin
                ir_q   <= cmd_ir;
                len_q  <= eff_len;
                data_q <= cmd_data;
                cap_q  <= '0;
            end else if (rise && (state_q == S_SHIFT)) begin
                cap_q[idx_q[IW-1:0]] <= tdo_bit;
            end
        end
    end

    assign rsp_data   = cap_q;
    assign jtag_TCK   = tck_q;
    assign jtag_TMS   = tms_q;
    assign jtag_TDI   = tdi_q;
    assign jtag_TRSTn = trstn_q;

endmodule
